// File: rtl/lc3b_mem_port_pkg.sv
// Shared LC-3b types for the memory port: FSM state encoding and
// default word geometry.
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lc3b_mem_state;

    localparam int unsigned LC3B_WORD_BYTES = 2;

    function automatic int unsigned lane_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/lc3b_mem_port_lane_align.sv
// Byte-lane steering: zero-extends a selected read lane, replicates a
// write byte across all lanes and builds the matching byte enables.
module mem_lane_align #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LANE_W     = $clog2(DATA_WIDTH / 8)
) (
    input  logic [LANE_W-1:0]       lane,
    input  logic                    is_byte,
    input  logic [DATA_WIDTH-1:0]   rd_word,
    input  logic [DATA_WIDTH-1:0]   wr_word,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] byte_en
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;

    always_comb begin
        rd_data = rd_word;
        wr_data = wr_word;
        byte_en = '1;
        if (is_byte) begin
            rd_data      = '0;
            rd_data[7:0] = rd_word[{lane, 3'b000} +: 8];
            wr_data      = {BYTES{wr_word[7:0]}};
            byte_en      = '0;
            byte_en[lane] = 1'b1;
        end
    end

endmodule

// File: rtl/lc3b_mem_port.sv
// LC-3b MAR/MDR memory-access unit: one request at a time, byte/word
// lanes, optional wait-state timeout reported through error with done.
module lc3b_mem_port
    import lc3b_types::*;
#(
    parameter int unsigned DATA_WIDTH = 8 * LC3B_WORD_BYTES,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_read,
    input  logic                    req_write,
    input  logic                    req_byte,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_resp
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned L     = lane_bits(DATA_WIDTH);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    lc3b_mem_state         state_q, state_d;
    logic [ADDR_WIDTH-1:0] mar_q, mar_d;
    logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
    logic [BYTES-1:0]      be_q, be_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  is_write_q, is_write_d;
    logic                  is_byte_q, is_byte_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [L-1:0]          lane_sel;
    logic                  byte_sel;
    logic [DATA_WIDTH-1:0] align_rd, align_wr;
    logic [BYTES-1:0]      align_be;

    // One aligner serves both paths: request lane while idle, MAR lane
    // once the access is in flight.
    assign lane_sel = (state_q == IDLE) ? req_addr[L-1:0] : mar_q[L-1:0];
    assign byte_sel = (state_q == IDLE) ? req_byte : is_byte_q;

    mem_lane_align #(
        .DATA_WIDTH(DATA_WIDTH),
        .LANE_W    (L)
    ) u_align (
        .lane   (lane_sel),
        .is_byte(byte_sel),
        .rd_word(mem_rdata),
        .wr_word(req_wdata),
        .rd_data(align_rd),
        .wr_data(align_wr),
        .byte_en(align_be)
    );

    always_comb begin
        state_d    = state_q;
        mar_d      = mar_q;
        mdr_d      = mdr_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        is_write_d = is_write_q;
        is_byte_d  = is_byte_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                err_d = 1'b0;
                if (req_read && req_write) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (req_read || req_write) begin
                    state_d    = ACCESS;
                    is_write_d = req_write;
                    is_byte_d  = req_byte;
                    mar_d      = req_byte ? req_addr
                                          : {req_addr[ADDR_WIDTH-1:L], {L{1'b0}}};
                    be_d       = align_be;
                    if (req_write) begin
                        mdr_d = align_wr;
                    end
                end
            end
            ACCESS: begin
                if (mem_resp) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    if (!is_write_q) begin
                        rdata_d = align_rd;
                    end
                end else if (TIMEOUT != 0 && cnt_q == CNT_W'(LIMIT)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mar_q      <= '0;
            mdr_q      <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
            is_write_q <= 1'b0;
            is_byte_q  <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
            is_write_q <= is_write_d;
            is_byte_q  <= is_byte_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy            = (state_q == ACCESS);
    assign done            = (state_q == DONE);
    assign error           = done & err_q;
    assign mem_read        = busy & ~is_write_q;
    assign mem_write       = busy & is_write_q;
    assign rdata           = rdata_q;
    assign mem_address     = mar_q;
    assign mem_wdata       = mdr_q;
    assign mem_byte_enable = be_q;

endmodule

// File: tb/tb_lc3b_mem_port.sv
// Directed bench for lc3b_mem_port: a 16-bit instance with TIMEOUT=4
// and a 32-bit instance with the timeout disabled.
module tb_lc3b_mem_port;

    logic clk;
    logic reset;

    logic        a_req_read, a_req_write, a_req_byte;
    logic [15:0] a_req_addr, a_req_wdata;
    logic        a_busy, a_done, a_error;
    logic [15:0] a_rdata, a_mem_address, a_mem_wdata, a_mem_rdata;
    logic        a_mem_read, a_mem_write, a_mem_resp;
    logic [1:0]  a_be;

    logic        b_req_read, b_req_write, b_req_byte;
    logic [15:0] b_req_addr;
    logic [31:0] b_req_wdata;
    logic        b_busy, b_done, b_error;
    logic [31:0] b_rdata, b_mem_wdata, b_mem_rdata;
    logic [15:0] b_mem_address;
    logic        b_mem_read, b_mem_write, b_mem_resp;
    logic [3:0]  b_be;

    int tests;
    int failed;

    lc3b_mem_port #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(16),
        .TIMEOUT   (4)
    ) dut_a (
        .clk            (clk),
        .reset          (reset),
        .req_read       (a_req_read),
        .req_write      (a_req_write),
        .req_byte       (a_req_byte),
        .req_addr       (a_req_addr),
        .req_wdata      (a_req_wdata),
        .busy           (a_busy),
        .done           (a_done),
        .error          (a_error),
        .rdata          (a_rdata),
        .mem_address    (a_mem_address),
        .mem_read       (a_mem_read),
        .mem_write      (a_mem_write),
        .mem_byte_enable(a_be),
        .mem_wdata      (a_mem_wdata),
        .mem_rdata      (a_mem_rdata),
        .mem_resp       (a_mem_resp)
    );

    lc3b_mem_port #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16),
        .TIMEOUT   (0)
    ) dut_b (
        .clk            (clk),
        .reset          (reset),
        .req_read       (b_req_read),
        .req_write      (b_req_write),
        .req_byte       (b_req_byte),
        .req_addr       (b_req_addr),
        .req_wdata      (b_req_wdata),
        .busy           (b_busy),
        .done           (b_done),
        .error          (b_error),
        .rdata          (b_rdata),
        .mem_address    (b_mem_address),
        .mem_read       (b_mem_read),
        .mem_write      (b_mem_write),
        .mem_byte_enable(b_be),
        .mem_wdata      (b_mem_wdata),
        .mem_rdata      (b_mem_rdata),
        .mem_resp       (b_mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic a_clear();
        a_req_read  = 1'b0;
        a_req_write = 1'b0;
        a_req_byte  = 1'b0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1'b1;
        a_clear();
        a_req_addr  = '0;
        a_req_wdata = '0;
        a_mem_rdata = '0;
        a_mem_resp  = 1'b0;
        b_req_read  = 1'b0;
        b_req_write = 1'b0;
        b_req_byte  = 1'b0;
        b_req_addr  = '0;
        b_req_wdata = '0;
        b_mem_rdata = '0;
        b_mem_resp  = 1'b0;

        tick();
        tick();
        reset = 1'b0;
        check("rst_busy",  {31'd0, a_busy}, 32'd0);
        check("rst_done",  {31'd0, a_done}, 32'd0);
        check("rst_error", {31'd0, a_error}, 32'd0);
        check("rst_rd",    {31'd0, a_mem_read}, 32'd0);
        check("rst_wr",    {31'd0, a_mem_write}, 32'd0);
        check("rst_rdata", {16'd0, a_rdata}, 32'd0);
        check("rst_addr",  {16'd0, a_mem_address}, 32'd0);
        check("rst_wdata", {16'd0, a_mem_wdata}, 32'd0);
        check("rst_be",    {30'd0, a_be}, 32'd0);

        // Word read at odd address, response after three strobe cycles
        a_req_read  = 1'b1;
        a_req_addr  = 16'h1235;
        a_mem_rdata = 16'hBEEF;
        tick();
        a_clear();
        check("wr1_busy", {31'd0, a_busy}, 32'd1);
        check("wr1_rd1",  {31'd0, a_mem_read}, 32'd1);
        check("wr1_addr", {16'd0, a_mem_address}, 32'h1234);
        check("wr1_be",   {30'd0, a_be}, 32'h3);
        tick();
        check("wr1_rd2",  {31'd0, a_mem_read}, 32'd1);
        tick();
        check("wr1_rd3",  {31'd0, a_mem_read}, 32'd1);
        a_mem_resp = 1'b1;
        tick();
        a_mem_resp = 1'b0;
        check("wr1_rd_off", {31'd0, a_mem_read}, 32'd0);
        check("wr1_done",   {31'd0, a_done}, 32'd1);
        check("wr1_err",    {31'd0, a_error}, 32'd0);
        check("wr1_rdata",  {16'd0, a_rdata}, 32'hBEEF);
        tick();
        check("wr1_done_off", {31'd0, a_done}, 32'd0);

        // Byte write to high lane
        a_req_write = 1'b1;
        a_req_byte  = 1'b1;
        a_req_addr  = 16'h0041;
        a_req_wdata = 16'h00A5;
        tick();
        a_clear();
        check("bw_wr",    {31'd0, a_mem_write}, 32'd1);
        check("bw_rd",    {31'd0, a_mem_read}, 32'd0);
        check("bw_wdata", {16'd0, a_mem_wdata}, 32'hA5A5);
        check("bw_be",    {30'd0, a_be}, 32'h2);
        check("bw_addr",  {16'd0, a_mem_address}, 32'h0041);
        tick();
        check("bw_wr2",   {31'd0, a_mem_write}, 32'd1);
        a_mem_resp = 1'b1;
        tick();
        a_mem_resp = 1'b0;
        check("bw_done",   {31'd0, a_done}, 32'd1);
        check("bw_err",    {31'd0, a_error}, 32'd0);
        check("bw_wr_off", {31'd0, a_mem_write}, 32'd0);
        tick();

        // Byte reads, both lanes, minimum latency
        a_req_read  = 1'b1;
        a_req_byte  = 1'b1;
        a_req_addr  = 16'h0040;
        a_mem_rdata = 16'h7F80;
        tick();
        a_clear();
        check("br0_be", {30'd0, a_be}, 32'h1);
        a_mem_resp = 1'b1;
        tick();
        a_mem_resp = 1'b0;
        check("br0_done",  {31'd0, a_done}, 32'd1);
        check("br0_rdata", {16'd0, a_rdata}, 32'h0080);
        tick();
        a_req_read = 1'b1;
        a_req_byte = 1'b1;
        a_req_addr = 16'h0041;
        tick();
        a_clear();
        check("br1_be", {30'd0, a_be}, 32'h2);
        a_mem_resp = 1'b1;
        tick();
        a_mem_resp = 1'b0;
        check("br1_done",  {31'd0, a_done}, 32'd1);
        check("br1_rdata", {16'd0, a_rdata}, 32'h007F);
        tick();

        // Timeout with no response
        a_req_read  = 1'b1;
        a_req_addr  = 16'h0010;
        a_mem_rdata = 16'h1111;
        tick();
        a_clear();
        check("to_rd1", {31'd0, a_mem_read}, 32'd1);
        tick();
        check("to_rd2", {31'd0, a_mem_read}, 32'd1);
        tick();
        check("to_rd3", {31'd0, a_mem_read}, 32'd1);
        tick();
        check("to_rd4", {31'd0, a_mem_read}, 32'd1);
        tick();
        check("to_rd_off", {31'd0, a_mem_read}, 32'd0);
        check("to_done",   {31'd0, a_done}, 32'd1);
        check("to_err",    {31'd0, a_error}, 32'd1);
        check("to_rdata",  {16'd0, a_rdata}, 32'h007F);
        tick();
        check("to_idle_done", {31'd0, a_done}, 32'd0);
        check("to_idle_err",  {31'd0, a_error}, 32'd0);

        // Response arriving on the expiry edge wins
        a_req_read = 1'b1;
        a_req_addr = 16'h0010;
        tick();
        a_clear();
        tick();
        tick();
        tick();
        check("tw_rd4", {31'd0, a_mem_read}, 32'd1);
        a_mem_rdata = 16'h2222;
        a_mem_resp  = 1'b1;
        tick();
        a_mem_resp = 1'b0;
        check("tw_done",  {31'd0, a_done}, 32'd1);
        check("tw_err",   {31'd0, a_error}, 32'd0);
        check("tw_rdata", {16'd0, a_rdata}, 32'h2222);
        tick();

        // Illegal request: both strobes requested
        a_req_read  = 1'b1;
        a_req_write = 1'b1;
        a_req_addr  = 16'h0500;
        tick();
        a_clear();
        check("il_done", {31'd0, a_done}, 32'd1);
        check("il_err",  {31'd0, a_error}, 32'd1);
        check("il_rd",   {31'd0, a_mem_read}, 32'd0);
        check("il_wr",   {31'd0, a_mem_write}, 32'd0);
        check("il_busy", {31'd0, a_busy}, 32'd0);
        tick();
        check("il_done_off", {31'd0, a_done}, 32'd0);
        check("il_rd_after", {31'd0, a_mem_read}, 32'd0);

        // Request while busy is ignored
        a_req_read = 1'b1;
        a_req_addr = 16'h0100;
        tick();
        a_req_read  = 1'b0;
        a_req_write = 1'b1;
        a_req_addr  = 16'h0200;
        tick();
        check("ig_addr", {16'd0, a_mem_address}, 32'h0100);
        check("ig_rd",   {31'd0, a_mem_read}, 32'd1);
        check("ig_wr",   {31'd0, a_mem_write}, 32'd0);
        a_clear();
        a_mem_resp = 1'b1;
        tick();
        a_mem_resp = 1'b0;
        check("ig_done", {31'd0, a_done}, 32'd1);
        tick();
        check("ig_no2_rd",   {31'd0, a_mem_read}, 32'd0);
        check("ig_no2_wr",   {31'd0, a_mem_write}, 32'd0);
        check("ig_no2_busy", {31'd0, a_busy}, 32'd0);

        // Stray response in IDLE
        a_mem_resp = 1'b1;
        tick();
        a_mem_resp = 1'b0;
        check("stray_done", {31'd0, a_done}, 32'd0);
        check("stray_busy", {31'd0, a_busy}, 32'd0);

        // 32-bit instance: byte read top lane, byte write lane 2, word align
        b_req_read  = 1'b1;
        b_req_byte  = 1'b1;
        b_req_addr  = 16'h0003;
        b_mem_rdata = 32'hDEADBEEF;
        tick();
        b_req_read = 1'b0;
        b_req_byte = 1'b0;
        check("b_br_be",   {28'd0, b_be}, 32'h8);
        check("b_br_addr", {16'd0, b_mem_address}, 32'h0003);
        b_mem_resp = 1'b1;
        tick();
        b_mem_resp = 1'b0;
        check("b_br_done",  {31'd0, b_done}, 32'd1);
        check("b_br_rdata", b_rdata, 32'h000000DE);
        tick();
        b_req_write = 1'b1;
        b_req_byte  = 1'b1;
        b_req_addr  = 16'h0002;
        b_req_wdata = 32'h1234565A;
        tick();
        b_req_write = 1'b0;
        b_req_byte  = 1'b0;
        check("b_bw_wdata", b_mem_wdata, 32'h5A5A5A5A);
        check("b_bw_be",    {28'd0, b_be}, 32'h4);
        b_mem_resp = 1'b1;
        tick();
        b_mem_resp = 1'b0;
        check("b_bw_done", {31'd0, b_done}, 32'd1);
        tick();
        b_req_read = 1'b1;
        b_req_addr = 16'h0007;
        tick();
        b_req_read = 1'b0;
        check("b_wr_addr", {16'd0, b_mem_address}, 32'h0004);
        check("b_wr_be",   {28'd0, b_be}, 32'hF);
        b_mem_resp = 1'b1;
        tick();
        b_mem_resp = 1'b0;
        check("b_wr_rdata", b_rdata, 32'hDEADBEEF);
        tick();

        // Reset in the middle of an access
        a_req_write = 1'b1;
        a_req_addr  = 16'h0300;
        a_req_wdata = 16'h5555;
        tick();
        a_clear();
        check("rm_wr_on", {31'd0, a_mem_write}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rm_wr",    {31'd0, a_mem_write}, 32'd0);
        check("rm_busy",  {31'd0, a_busy}, 32'd0);
        check("rm_done",  {31'd0, a_done}, 32'd0);
        check("rm_addr",  {16'd0, a_mem_address}, 32'd0);
        check("rm_wdata", {16'd0, a_mem_wdata}, 32'd0);
        check("rm_rdata", {16'd0, a_rdata}, 32'd0);
        check("rm_be",    {30'd0, a_be}, 32'd0);
        tick();
        check("rm_done_after", {31'd0, a_done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/lc3b_mem_port.md
Name: lc3b_mem_port

Overview:
Parametrised multi-cycle memory-access unit. It holds the MAR/MDR pair and runs the read/write handshake to memory for the LC-3b datapath. It adds byte-lane accesses for LDB/STB, configurable data and address width, and an optional wait-state timeout with error reporting. The datapath issues one request at a time; the control FSM waits on done.

Parameters:
DATA_WIDTH, 16, memory word width in bits; must be a multiple of 8 and at least 16
ADDR_WIDTH, 16, byte-address width
TIMEOUT, 0, maximum cycles to wait for mem_resp; 0 disables the timeout

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_read  in  1  start a read (sampled in IDLE only)
req_write  in  1  start a write (sampled in IDLE only)
req_byte  in  1  byte access (1) or word access (0)
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data; byte writes use bits [7:0]
busy  out  1  high from the cycle after acceptance until done
done  out  1  one-cycle completion pulse
error  out  1  qualifies done: access failed (timeout or illegal request)
rdata  out  DATA_WIDTH  read result; valid with done, held until the next done
mem_address  out  ADDR_WIDTH  MAR contents
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_byte_enable  out  DATA_WIDTH/8  active lanes
mem_wdata  out  DATA_WIDTH  MDR contents
mem_rdata  in  DATA_WIDTH  memory read data
mem_resp  in  1  memory completion

Behaviour:
- Clock and reset fixed: one clock, clk; reset synchronous, active-high.
- Let B = DATA_WIDTH/8 and L = log2(B).
- Reset values: state=IDLE, busy=0, done=0, error=0, mem_read=0, mem_write=0, rdata=0, mem_address=0, mem_wdata=0, mem_byte_enable=0.
- States:
  - IDLE: accepts requests.
  - ACCESS: strobe held until mem_resp or timeout.
  - DONE: single cycle; drives done, returns to IDLE.
- Accept (IDLE, exactly one of req_read/req_write high) at edge N:
  - MAR gets req_addr; for word access the low L bits are cleared.
  - Word write: MDR gets req_wdata.
  - Byte write: MDR gets req_wdata[7:0] replicated into all B lanes.
  - mem_byte_enable: word = all ones; byte = one-hot at lane req_addr[L-1:0].
  - Next state ACCESS.
- ACCESS:
  - busy=1; mem_read or mem_write=1, stable, with address/data/enable unchanged.
  - mem_resp=1 at edge M:
    - Read latches rdata. Word = mem_rdata. Byte = selected lane, zero-extended to DATA_WIDTH.
    - Strobe drops at M; state DONE; done=1, error=0 during cycle M..M+1.
  - Minimum latency: accept edge N, resp sampled at N+1, done high in cycle after N+1.
- Timeout (TIMEOUT>0):
  - Wait counter increments each ACCESS cycle without mem_resp.
  - On reaching TIMEOUT: strobe drops, rdata unchanged, DONE with error=1.
  - mem_resp on the same edge as expiry wins; no error.
- req_read and req_write both high in IDLE: no memory access; go straight to DONE with error=1.
- Requests outside IDLE are ignored and not queued.
- mem_resp outside ACCESS is ignored.
- reset mid-ACCESS: strobes deassert at that edge, no done pulse; the in-flight access is abandoned.
- The counter saturates; it never wraps within an access.

Decomposition:
- lc3b_types package gains lc3b_mem_state enum (IDLE, ACCESS, DONE) and the constant LC3B_WORD_BYTES=2 for the default instance.
- One sub-module, mem_lane_align (combinational): given lane index, data and byte flag, produces the read zero-extension and write replication. Reused by later cache work.

Test Plan:
- Word read, addr 0x1235, mem_resp after 3 cycles, mem_rdata 0xBEEF -> mem_address 0x1234, byte_enable 2'b11, mem_read high 3 cycles, done+rdata 0xBEEF, error=0.
- Byte write, addr 0x0041, wdata 0x00A5 -> mem_wdata 0xA5A5, byte_enable 2'b10, mem_write until resp, done, error=0.
- Byte read, addr 0x0040, mem_rdata 0x7F80 -> rdata 0x0080; addr 0x0041 -> rdata 0x007F.
- TIMEOUT=4, no mem_resp -> mem_read high exactly 4 cycles, then done=1, error=1, rdata unchanged; repeat with resp on cycle 4 -> error=0.
- req_read=req_write=1 -> no strobe ever; done=1, error=1 the next cycle. New request while busy -> ignored, no second access.
- reset asserted during ACCESS -> next cycle all outputs at reset values, no done; DATA_WIDTH=32 instance: byte read at addr 0x3 -> byte_enable 4'b1000, rdata = mem_rdata[31:24] zero-extended.
